// File: rtl/electr_config_loader.sv
// -----------------------------------------------------------------------------
// electr_config_loader
//
// Upstream feeder for the electrode-configuration serializer. Configuration
// bytes arrive over a valid/ready handshake and are packed LSB-first into an
// N_ELECTRODES-wide vector. After the final beat the vector is published on
// electr_config_out and enable_desp pulses for one cycle. The loader then
// waits for a rising edge of sr_finish (success) or a cycle limit (timeout)
// before it goes back to collecting.
//
// Ports:
//   CLK               in   system clock, rising edge
//   RST               in   synchronous active-high reset
//   byte_in           in   configuration data beat (BYTE_W bits)
//   byte_valid        in   byte_in is valid
//   byte_ready        out  loader accepts a beat (COLLECT only)
//   cfg_abort         in   cancel collection/transfer in progress
//   sr_finish         in   serializer completion flag (edge-detected)
//   electr_config_out out  assembled configuration (N_ELECTRODES bits)
//   enable_desp       out  one-cycle start pulse to the serializer
//   busy              out  high in LAUNCH and WAIT_FIN
//   cfg_done          out  one-cycle pulse on successful transfer
//   cfg_error         out  one-cycle pulse on timeout
// -----------------------------------------------------------------------------
module electr_config_loader #(
  parameter int N_ELECTRODES   = 55,
  parameter int BYTE_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [BYTE_W-1:0]       byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  input  logic                    cfg_abort,
  input  logic                    sr_finish,
  output logic [N_ELECTRODES-1:0] electr_config_out,
  output logic                    enable_desp,
  output logic                    busy,
  output logic                    cfg_done,
  output logic                    cfg_error
);

  localparam int N_BYTES = (N_ELECTRODES + BYTE_W - 1) / BYTE_W;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_LAUNCH   = 2'd1,
    S_WAIT_FIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_byte_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_sr_finish_d;
  logic [N_ELECTRODES-1:0] r_shadow;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_finish_evt;
  logic [TO_W-1:0]         w_to_next;
  logic [N_ELECTRODES-1:0] w_next_shadow;

  // Handshake decode, sr_finish edge detect and timeout increment.
  always_comb begin
    w_accept     = (r_state == S_COLLECT) && byte_valid && byte_ready;
    w_last       = (r_byte_cnt == CNT_W'(N_BYTES - 1));
    // Only a fresh 0->1 transition counts, so a level left high from an
    // earlier transfer cannot complete a new one.
    w_finish_evt = sr_finish & ~r_sr_finish_d;
    w_to_next    = r_to_cnt + TO_W'(1);
  end

  // Shadow with the current beat merged into its slot; bits of the final beat
  // above N_ELECTRODES-1 have no destination and fall away here.
  always_comb begin
    w_next_shadow = r_shadow;
    for (int i = 0; i < N_ELECTRODES; i++) begin
      if ((i / BYTE_W) == int'(r_byte_cnt)) begin
        w_next_shadow[i] = byte_in[i % BYTE_W];
      end else begin
        w_next_shadow[i] = r_shadow[i];
      end
    end
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state           <= S_COLLECT;
      r_byte_cnt        <= '0;
      r_to_cnt          <= '0;
      r_sr_finish_d     <= 1'b0;
      r_shadow          <= '0;
      electr_config_out <= '0;
      enable_desp       <= 1'b0;
      busy              <= 1'b0;
      cfg_done          <= 1'b0;
      cfg_error         <= 1'b0;
      byte_ready        <= 1'b0;
    end else begin
      r_sr_finish_d <= sr_finish;
      enable_desp   <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
      if (cfg_abort) begin
        // Abort beats everything else, including a coinciding final beat.
        r_state    <= S_COLLECT;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
        r_shadow   <= '0;
        busy       <= 1'b0;
        byte_ready <= 1'b1;
      end else begin
        case (r_state)
          S_COLLECT: begin
            byte_ready <= 1'b1;
            busy       <= 1'b0;
            if (w_accept) begin
              if (w_last) begin
                electr_config_out <= w_next_shadow;
                r_shadow          <= '0;
                r_byte_cnt        <= '0;
                r_state           <= S_LAUNCH;
                enable_desp       <= 1'b1;
                busy              <= 1'b1;
                byte_ready        <= 1'b0;
              end else begin
                r_shadow   <= w_next_shadow;
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
              end
            end else begin
              r_byte_cnt <= r_byte_cnt;
            end
          end
          S_LAUNCH: begin
            r_to_cnt   <= '0;
            busy       <= 1'b1;
            byte_ready <= 1'b0;
            r_state    <= S_WAIT_FIN;
          end
          S_WAIT_FIN: begin
            if (w_finish_evt) begin
              // Success wins over a timeout landing on the same cycle.
              cfg_done   <= 1'b1;
              r_state    <= S_COLLECT;
              r_to_cnt   <= '0;
              busy       <= 1'b0;
              byte_ready <= 1'b1;
            end else if (w_to_next == TO_W'(TIMEOUT_CYCLES)) begin
              cfg_error  <= 1'b1;
              r_state    <= S_COLLECT;
              r_to_cnt   <= '0;
              busy       <= 1'b0;
              byte_ready <= 1'b1;
            end else begin
              r_to_cnt   <= w_to_next;
              busy       <= 1'b1;
              byte_ready <= 1'b0;
            end
          end
          default: begin
            r_state    <= S_COLLECT;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
            busy       <= 1'b0;
            byte_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_electr_config_loader.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for electr_config_loader (default parameters).
// Inputs change #1 after a rising edge; outputs are sampled at that same point,
// i.e. they reflect the registers updated by the preceding edge.
// -----------------------------------------------------------------------------
module tb_electr_config_loader;

  localparam int TO = 1023;

  logic        CLK;
  logic        RST;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        cfg_abort;
  logic        sr_finish;
  logic [54:0] electr_config_out;
  logic        enable_desp;
  logic        busy;
  logic        cfg_done;
  logic        cfg_error;

  int checks;
  int errors;
  int ep_cnt;

  electr_config_loader #(
    .N_ELECTRODES  (55),
    .BYTE_W        (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .cfg_abort        (cfg_abort),
    .sr_finish        (sr_finish),
    .electr_config_out(electr_config_out),
    .enable_desp      (enable_desp),
    .busy             (busy),
    .cfg_done         (cfg_done),
    .cfg_error        (cfg_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle; also counts launch pulses and watches done/error overlap.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (enable_desp) ep_cnt++;
    if (cfg_done && cfg_error) begin
      errors++;
      $display("FAIL done_error_overlap: done=%0b error=%0b, required not both", cfg_done, cfg_error);
    end
  endtask

  // Send n beats of v (beat k = v[8k+:8]); optionally abort on the last edge.
  task automatic send_beats(input logic [55:0] v, input int n, input bit abort_last);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      byte_in    = v[k*8 +: 8];
      byte_valid = 1'b1;
      while (!byte_ready && w < 20) begin
        tick();
        w++;
      end
      checks++;
      if (byte_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_wait: byte_ready=%0b, required 1", byte_ready);
      end
      if (abort_last && k == n - 1) cfg_abort = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    cfg_abort  = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({byte_ready, enable_desp, busy, cfg_done, cfg_error} !== 5'b0 || electr_config_out !== 55'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b en=%0b busy=%0b done=%0b err=%0b out=%h, required all 0",
               byte_ready, enable_desp, busy, cfg_done, cfg_error, electr_config_out);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: byte_ready=%0b, required 1", byte_ready);
    end
  endtask

  task automatic test_basic_load();
    send_beats(56'h0000_3A_A5_5A_A3_FF, 7, 1'b0);
    checks++;
    if (electr_config_out !== 55'h3AA55AA3FF || enable_desp !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_launch: out=%h en=%0b busy=%0b rdy=%0b, required 3aa55aa3ff 1 1 0",
               electr_config_out, enable_desp, busy, byte_ready);
    end
    tick();
    checks++;
    if (enable_desp !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse_width: en=%0b busy=%0b, required 0 1", enable_desp, busy);
    end
    for (int i = 0; i < 59; i++) tick();
    checks++;
    if (cfg_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait: done=%0b busy=%0b, required 0 1", cfg_done, busy);
    end
    sr_finish = 1'b1;
    tick();
    checks++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%0b err=%0b busy=%0b, required 1 0 0", cfg_done, cfg_error, busy);
    end
    sr_finish = 1'b0;
    tick();
    checks++;
    if (cfg_done !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_done: done=%0b rdy=%0b, required 0 1", cfg_done, byte_ready);
    end
  endtask

  task automatic test_final_beat_trunc();
    send_beats(56'hFF_00_00_00_00_00_00, 7, 1'b0);
    checks++;
    if (electr_config_out !== 55'h7F000000000000 || enable_desp !== 1'b1) begin
      errors++;
      $display("FAIL trunc_out: out=%h en=%0b, required 7f000000000000 1", electr_config_out, enable_desp);
    end
    tick();
    tick();
    sr_finish = 1'b1;
    tick();
    checks++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL trunc_done: done=%0b, required 1", cfg_done);
    end
    sr_finish = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int  n;
    bit  saw_done;
    n = 0;
    saw_done = 1'b0;
    send_beats(56'h77_66_55_44_33_22_11, 7, 1'b0);
    while (!cfg_error && n < 1100) begin
      tick();
      n++;
      if (cfg_done) saw_done = 1'b1;
    end
    checks++;
    if (n !== TO + 1 || saw_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_latency: cycles=%0d done_seen=%0b, required %0d 0", n, saw_done, TO + 1);
    end
    checks++;
    if (electr_config_out !== 55'h77665544332211 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold: out=%h busy=%0b, required 77665544332211 0", electr_config_out, busy);
    end
    tick();
    checks++;
    if (cfg_error !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: err=%0b rdy=%0b, required 0 1", cfg_error, byte_ready);
    end
  endtask

  task automatic test_stale_finish();
    int  n;
    bit  saw_done;
    n = 0;
    saw_done = 1'b0;
    sr_finish = 1'b1;
    tick();
    send_beats(56'h07_06_05_04_03_02_01, 7, 1'b0);
    while (!cfg_error && n < 1100) begin
      tick();
      n++;
      if (cfg_done) saw_done = 1'b1;
    end
    checks++;
    if (n !== TO + 1 || saw_done !== 1'b0) begin
      errors++;
      $display("FAIL stale_finish: cycles=%0d done_seen=%0b, required %0d 0", n, saw_done, TO + 1);
    end
    send_beats(56'h0E_0D_0C_0B_0A_09_08, 7, 1'b0);
    tick();
    tick();
    sr_finish = 1'b0;
    tick();
    sr_finish = 1'b1;
    tick();
    checks++;
    if (cfg_done !== 1'b1 || electr_config_out !== 55'h0E0D0C0B0A0908) begin
      errors++;
      $display("FAIL stale_then_edge: done=%0b out=%h, required 1 0e0d0c0b0a0908", cfg_done, electr_config_out);
    end
    sr_finish = 1'b0;
    tick();
  endtask

  task automatic test_tie_success_wins();
    send_beats(56'h01_23_45_67_89_AB_CD, 7, 1'b0);
    for (int i = 0; i < TO; i++) tick();
    sr_finish = 1'b1;
    tick();
    checks++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL tie_success: done=%0b err=%0b, required 1 0", cfg_done, cfg_error);
    end
    sr_finish = 1'b0;
    tick();
    checks++;
    if (cfg_error !== 1'b0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL tie_no_late_error: done=%0b err=%0b, required 0 0", cfg_done, cfg_error);
    end
  endtask

  task automatic test_abort_partial();
    ep_cnt = 0;
    send_beats(56'h00_00_00_DD_CC_BB_AA, 4, 1'b0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    checks++;
    if (electr_config_out !== 55'h0123456789ABCD || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: out=%h busy=%0b, required 0123456789abcd 0", electr_config_out, busy);
    end
    send_beats(56'h70_60_50_40_30_20_10, 7, 1'b0);
    tick();
    tick();
    checks++;
    if (electr_config_out !== 55'h70605040302010 || ep_cnt !== 1) begin
      errors++;
      $display("FAIL abort_fresh: out=%h pulses=%0d, required 70605040302010 1", electr_config_out, ep_cnt);
    end
    sr_finish = 1'b1;
    tick();
    sr_finish = 1'b0;
    tick();
  endtask

  task automatic test_abort_final_beat();
    ep_cnt = 0;
    send_beats(56'h11_11_11_11_11_11_11, 7, 1'b1);
    tick();
    checks++;
    if (ep_cnt !== 0 || electr_config_out !== 55'h70605040302010 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_final: pulses=%0d out=%h rdy=%0b, required 0 70605040302010 1",
               ep_cnt, electr_config_out, byte_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    bit saw;
    saw = 1'b0;
    send_beats(56'h22_33_44_55_66_77_08, 7, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    sr_finish = 1'b1;
    tick();
    checks++;
    if ({byte_ready, enable_desp, busy, cfg_done, cfg_error} !== 5'b0 || electr_config_out !== 55'h0) begin
      errors++;
      $display("FAIL rst_wait_outputs: rdy=%0b en=%0b busy=%0b done=%0b err=%0b out=%h, required all 0",
               byte_ready, enable_desp, busy, cfg_done, cfg_error, electr_config_out);
    end
    RST = 1'b0;
    sr_finish = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cfg_done || cfg_error) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_no_pulse: pulse_seen=%0b, required 0", saw);
    end
    send_beats(56'h0000_3A_A5_5A_A3_FF, 7, 1'b0);
    checks++;
    if (electr_config_out !== 55'h3AA55AA3FF || enable_desp !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_reload: out=%h en=%0b busy=%0b, required 3aa55aa3ff 1 1",
               electr_config_out, enable_desp, busy);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ep_cnt     = 0;
    RST        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    cfg_abort  = 1'b0;
    sr_finish  = 1'b0;
    #1;
    test_reset();
    test_basic_load();
    test_final_beat_trunc();
    test_timeout();
    test_stale_finish();
    test_tie_success_wins();
    test_abort_partial();
    test_abort_final_beat();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/electr_config_loader.md
Name: electr_config_loader

Overview:
Upstream feeder for the electrode-configuration serializer. It accepts the electrode configuration as a stream of bytes over a valid/ready handshake and assembles them into an N_ELECTRODES-wide vector. It then presents the vector on electr_config_out, pulses enable_desp for one cycle, and waits for the serializer's sr_finish. It reports completion or timeout and then returns to collecting the next configuration.

Parameters:
N_ELECTRODES, 55, width of the assembled configuration vector (number of electrodes).
BYTE_W, 8, width of each input data beat.
TIMEOUT_CYCLES, 1023, maximum number of cycles to wait for sr_finish after launch; must be >= 1.
(derived) N_BYTES = ceil(N_ELECTRODES/BYTE_W), which is 7 with the defaults.

Ports:
CLK  input  1  system clock; all logic is on its rising edge.
RST  input  1  synchronous, active-high reset.
byte_in  input  BYTE_W  configuration data beat.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader can accept a beat.
cfg_abort  input  1  cancels the collection or transfer in progress.
sr_finish  input  1  serializer completion flag.
electr_config_out  output  N_ELECTRODES  assembled configuration; drives the serializer's electr_config_in.
enable_desp  output  1  one-cycle start pulse to the serializer.
busy  output  1  high in LAUNCH and WAIT_FIN.
cfg_done  output  1  one-cycle pulse on successful transfer.
cfg_error  output  1  one-cycle pulse on timeout.

Behaviour:
- All outputs are registered.
- Reset values: electr_config_out=0, enable_desp=0, busy=0, cfg_done=0, cfg_error=0, byte_ready=0 during reset. Internal state: byte counter=0, timeout counter=0, sr_finish_d=0, state=COLLECT.
- Reset asserted mid-operation: the same values apply on the next edge, with no pulse emitted.
- States: COLLECT, LAUNCH, WAIT_FIN.
- COLLECT:
  - byte_ready=1.
  - A beat is accepted when byte_valid && byte_ready.
  - Beat k (k=0..N_BYTES-1) writes shadow bits [k*BYTE_W +: BYTE_W], LSB-first.
  - In the final beat, bits at positions >= N_ELECTRODES are discarded.
  - Byte counter increments per accepted beat.
  - On acceptance of beat N_BYTES-1, at the same edge: electr_config_out <= full assembled vector, byte counter <= 0, state <= LAUNCH.
  - byte_valid with byte_ready=0 is ignored (no data captured).
- LAUNCH (exactly 1 cycle):
  - enable_desp=1, busy=1, byte_ready=0. Timeout counter cleared.
  - Next state is WAIT_FIN.
  - Latency: last beat accepted at edge t, enable_desp high during cycle t+1.
- WAIT_FIN:
  - busy=1, byte_ready=0, enable_desp=0.
  - sr_finish_d is registered every cycle; finish_evt = sr_finish & ~sr_finish_d.
  - A sr_finish level left high from an earlier transfer never completes a new one.
  - finish_evt -> cfg_done=1 for one cycle, state <= COLLECT.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES: cfg_error=1 for one cycle, state <= COLLECT.
  - finish_evt in the same cycle the counter reaches its limit: success wins (cfg_done only).
- electr_config_out is held stable from LAUNCH until the next successful final-beat acceptance. It is never changed by abort, timeout or partial collection.
- cfg_abort, sampled in any state:
  - State <= COLLECT, byte counter <= 0, partial shadow discarded, no cfg_done or cfg_error.
  - Abort in LAUNCH suppresses nothing already driven, but no WAIT_FIN follows.
  - Abort coinciding with a final-beat acceptance: abort wins, and the beat is not captured.
- RST has priority over cfg_abort, which has priority over all other events.
- cfg_done and cfg_error are mutually exclusive and never asserted for more than one cycle.

Test Plan:
1. Reset, then send beats FF,A3,5A,A5,3A,00,00 with valid continuously high -> electr_config_out=55'h3AA55AA3FF one cycle after the 7th beat, enable_desp high exactly 1 cycle, busy=1. sr_finish rising 60 cycles later -> cfg_done pulse, byte_ready=1 the following cycle.
2. Final beat 0xFF with all other beats 00 -> electr_config_out=55'h7F000000000000; upper bit of the final beat dropped.
3. sr_finish held low after launch -> cfg_error pulse exactly TIMEOUT_CYCLES+1 cycles after enable_desp, no cfg_done; electr_config_out unchanged.
4. sr_finish held high from before launch and never toggled -> no cfg_done, timeout fires; a later 0->1 edge in the next transfer completes normally.
5. Abort after 4 of 7 beats, then send 7 fresh beats -> only fresh data appears; one enable_desp pulse total.
6. RST asserted during WAIT_FIN -> all outputs 0 next cycle, no cfg_done or cfg_error; a subsequent full 7-beat load launches normally.
